// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug/readback blocks.
// Holds the dump engine state encoding and the byte-stream framing constants.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4,
        ST_FIN  = 3'd5
    } dump_state_e;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'd3;
    localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/dm_dump.sv
// Data-memory readback engine: reads a word window through a synchronous read
// port and streams it little-endian with valid/ready, then one XOR checksum byte.
module dm_dump
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [DATA_W-1:0] shift_r;
    logic [1:0]        idx_r;
    logic [7:0]        csum_r;
    logic              hs_s;

    assign hs_s = tx_valid & tx_ready;

    // Dump sequencer; every output is a register loaded on the transition into its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= {(ADDR_W+1){1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            idx_r       <= 2'd0;
            csum_r      <= CSUM_INIT;
            mem_rd_en   <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_r      <= base;
                        remaining_r <= count;
                        csum_r      <= CSUM_INIT;
                        busy        <= 1'b1;
                        if (count == {(ADDR_W+1){1'b0}}) begin
                            state_r  <= ST_CSUM;
                            tx_data  <= CSUM_INIT;
                            tx_valid <= 1'b1;
                        end else begin
                            state_r   <= ST_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base;
                        end
                    end
                end
                ST_RD: begin
                    mem_rd_en <= 1'b0;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Byte 0 goes straight to tx_data; shift_r keeps the bytes still to send.
                    tx_data     <= mem_rdata[7:0];
                    shift_r     <= mem_rdata >> 8;
                    tx_valid    <= 1'b1;
                    idx_r       <= 2'd0;
                    addr_r      <= addr_r + 1'b1;
                    remaining_r <= remaining_r - 1'b1;
                    state_r     <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs_s) begin
                        csum_r <= csum_r ^ tx_data;
                        idx_r  <= idx_r + 2'd1;
                        if (idx_r == LAST_BYTE_IDX) begin
                            if (remaining_r != {(ADDR_W+1){1'b0}}) begin
                                state_r   <= ST_RD;
                                tx_valid  <= 1'b0;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= addr_r;
                            end else begin
                                state_r <= ST_CSUM;
                                tx_data <= csum_r ^ tx_data;
                            end
                        end else begin
                            tx_data <= shift_r[7:0];
                            shift_r <= shift_r >> 8;
                        end
                    end
                end
                ST_CSUM: begin
                    if (hs_s) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_rd_en <= 1'b0;
                    tx_valid  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_dump.sv
// Self-checking bench for dm_dump: table of dump windows plus directed
// sequences for byte order, address wrap, back-pressure and mid-run reset.
module tb_dm_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base = 10'h000;
    logic [10:0] count = 11'd0;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    dm_dump #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory model.
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q [$];
    logic [9:0] addr_q [$];
    int         done_cyc;
    int         first_vcyc;
    int         rd_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete dump; cycle 1 is the cycle after the start pulse is sampled.
    task automatic run_dump(input logic [9:0] b, input logic [10:0] n,
                            input int ready_pct, input int poke_cyc);
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        byte_q.delete();
        addr_q.delete();
        done_cyc   = -1;
        first_vcyc = -1;
        rd_cnt     = 0;
        @(negedge clk);
        base = b; count = n; start = 1'b1; tx_ready = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            base  = 10'h155;
            count = 11'd7;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (mem_rd_en) begin
                rd_cnt++;
                addr_q.push_back(mem_addr);
            end
            if (tx_valid && first_vcyc < 0) first_vcyc = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tx_valid && tx_ready) byte_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
        start = 1'b0;
        tx_ready = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("idle_after", {28'd0, busy, tx_valid, mem_rd_en, done}, 32'd0);
    endtask

    typedef struct {
        logic [9:0]  b;
        logic [10:0] n;
        logic [7:0]  csum;
        int          done_c;
        int          first_v;
        int          poke;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_single [5];
    logic [7:0] exp_wrap [13];
    logic [9:0] exp_waddr [3];
    logic [7:0] model_q [$];
    logic [7:0] x;
    int         nhs;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'h12345678;
        mem[10'h011] = 32'hA5A50F0F;
        mem[10'h012] = 32'hDEADBEEF;
        mem[10'h3FE] = 32'h00000001;
        mem[10'h3FF] = 32'h00000002;
        mem[10'h000] = 32'h00000003;
        for (int i = 0; i < 16; i++) mem[10'h100 + i] = 32'h11111111 + i * 32'h01020304;

        vecs[0] = '{10'h010, 11'd1, 8'h08, 8,  3, 0};
        vecs[1] = '{10'h3FE, 11'd3, 8'h00, 20, 3, 0};
        vecs[2] = '{10'h000, 11'd0, 8'h00, 2,  1, 1};
        vecs[3] = '{10'h010, 11'd2, 8'h08, 14, 3, 0};
        vecs[4] = '{10'h3FF, 11'd2, 8'h01, 14, 3, 0};
        exp_single = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        exp_wrap   = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                       8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_waddr  = '{10'h3FE, 10'h3FF, 10'h000};

        // Reset, then idle with no start.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs", {12'd0, mem_rd_en, tx_valid, busy, done, mem_addr, tx_data}, 32'd0);
        end

        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].b, vecs[v].n, 100, vecs[v].poke);
            chk("done_cycle", done_cyc, vecs[v].done_c);
            chk("first_valid", first_vcyc, vecs[v].first_v);
            chk("nbytes", byte_q.size(), int'(vecs[v].n) * 4 + 1);
            chk("rd_count", rd_cnt, int'(vecs[v].n));
            if (byte_q.size() > 0) chk("csum", {24'd0, byte_q[$]}, {24'd0, vecs[v].csum});
            else chk("csum_present", 32'd0, 32'd1);
        end

        // Single word byte order.
        run_dump(10'h010, 11'd1, 100, 0);
        chk("single_len", byte_q.size(), 5);
        for (int i = 0; i < 5 && i < byte_q.size(); i++)
            chk("single_byte", {24'd0, byte_q[i]}, {24'd0, exp_single[i]});

        // Address wrap-around.
        run_dump(10'h3FE, 11'd3, 100, 0);
        chk("wrap_len", byte_q.size(), 13);
        chk("wrap_nrd", addr_q.size(), 3);
        for (int i = 0; i < 13 && i < byte_q.size(); i++)
            chk("wrap_byte", {24'd0, byte_q[i]}, {24'd0, exp_wrap[i]});
        for (int i = 0; i < 3 && i < addr_q.size(); i++)
            chk("wrap_addr", {22'd0, addr_q[i]}, {22'd0, exp_waddr[i]});

        // Back-pressure on 16 words with a stray start while busy.
        model_q.delete();
        x = 8'h00;
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++) begin
                model_q.push_back(mem[10'h100 + w][k*8 +: 8]);
                x = x ^ mem[10'h100 + w][k*8 +: 8];
            end
        model_q.push_back(x);
        run_dump(10'h100, 11'd16, 30, 5);
        chk("bp_len", byte_q.size(), 65);
        chk("bp_nrd", rd_cnt, 16);
        for (int i = 0; i < 65 && i < byte_q.size(); i++)
            chk("bp_byte", {24'd0, byte_q[i]}, {24'd0, model_q[i]});
        for (int i = 0; i < 16 && i < addr_q.size(); i++)
            chk("bp_addr", {22'd0, addr_q[i]}, 32'h100 + i);

        // Reset during the second byte of word 2.
        @(negedge clk);
        base = 10'h010; count = 11'd3; start = 1'b1; tx_ready = 1'b1;
        nhs = 0;
        for (int c = 0; c < 100 && nhs < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_valid) nhs++;
        end
        chk("mid_reached", nhs, 6);
        #2 rst = 1'b0;
        #1 chk("rst_async", {12'd0, mem_rd_en, tx_valid, busy, done, mem_addr, tx_data}, 32'd0);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {29'd0, done, busy, tx_valid}, 32'd0);
        end
        rst = 1'b1;
        run_dump(10'h010, 11'd1, 100, 0);
        chk("post_rst_done", done_cyc, 8);
        chk("post_rst_len", byte_q.size(), 5);
        for (int i = 0; i < 5 && i < byte_q.size(); i++)
            chk("post_rst_byte", {24'd0, byte_q[i]}, {24'd0, exp_single[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dm_dump.md
# dm_dump

Post-run data-memory readback engine for the pipelined MIPS core. On a start pulse it reads a contiguous window of data-memory words through a synchronous read port and serialises them as a little-endian byte stream with valid/ready flow control, followed by one XOR checksum byte. It sits beside the data memory, on the readback side, so simulation and FPGA runs can export data memory without hierarchical access.

## Interface
- ADDR_W, 10: word-address width of data memory (1024 words).
- DATA_W, 32: memory word width; fixed at 32 (4 bytes per word).

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle request; sampled only in IDLE.
- base  in  ADDR_W  first word address, latched on accepted start.
- count  in  ADDR_W+1  number of words (0..2^ADDR_W), latched on accepted start.
- mem_rd_en  out  1  read strobe to data memory.
- mem_addr  out  ADDR_W  word address for the read.
- mem_rdata  in  32  read data, valid exactly one cycle after mem_rd_en.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation
- States: IDLE, RD, WAIT, SEND, CSUM, FIN.
- IDLE: start=1 latches base into addr register, count into remaining, clears checksum to 0x00, goes to RD; if count=0, goes directly to CSUM.
- RD: mem_rd_en=1, mem_addr=addr; next WAIT.
- WAIT: mem_rdata captured into 32-bit shift register; byte index cleared to 0; addr increments modulo 2^ADDR_W (wraps 0x3FF -> 0x000); remaining decrements; next SEND.
- SEND: tx_valid=1, tx_data=shift[7:0]. On handshake: checksum ^= tx_data, shift right 8, index++. After 4th handshake: next RD if remaining>0, else CSUM.
- CSUM: tx_valid=1, tx_data=checksum; on handshake next FIN.
- FIN: done=1 for one cycle; next IDLE.
- start outside IDLE is ignored; base/count changes after acceptance have no effect.
- tx_data and tx_valid hold stable while tx_valid=1 and tx_ready=0.
- busy = (state != IDLE).

## Timing
- Reset (rst=0, asynchronous): state IDLE; mem_rd_en=0, mem_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, checksum=0. Reset mid-transfer aborts immediately; no done pulse; next start begins fresh.
- start at cycle 0 -> mem_rd_en at cycle 1 -> first tx_valid at cycle 3.
- With tx_ready held 1: each word costs 6 cycles (RD, WAIT, 4x SEND); N words finish with checksum byte at cycle 1+6N+... precisely: CSUM at cycle 6N+1, done at cycle 6N+2 (N>0); N=0: CSUM at cycle 1, done at cycle 2.
- Only one read outstanding; mem_rd_en never asserted outside RD.
- Back-pressure stalls in SEND/CSUM indefinitely without losing data.

## Structure
- Shared package mips_dbg_pkg: state enum type, BYTES_PER_WORD=4, CSUM_INIT=8'h00.
- Single module; no sub-module required. Optional sub-module dump_ser (32-bit to byte serialiser with checksum) if reused by a future instruction-memory dump.

## Test plan
- Reset/idle: hold rst=0 then release, no start -> all outputs 0, busy=0 for 20 cycles.
- Single word: mem[0x010]=0x12345678, base=0x010, count=1, tx_ready=1 -> bytes 78,56,34,12, checksum 0x08; done at cycle 8.
- Wrap-around: base=0x3FE, count=3, mem[0x3FE]=0x1, mem[0x3FF]=0x2, mem[0x000]=0x3 -> mem_addr sequence 3FE,3FF,000; bytes 01,00,00,00,02,00,00,00,03,00,00,00,00.
- Back-pressure: tx_ready random 30% duty on 16-word dump -> byte sequence identical to ready=1 run; tx_data stable whenever valid&&!ready.
- count=0 -> single byte 0x00, done at cycle 2, mem_rd_en never asserted; start pulses during busy ignored.
- Reset mid-operation: rst=0 during SEND of word 2 -> outputs return to reset values asynchronously, no done; new start with count=1 completes normally.
